// File: rtl/cdb_arbiter_if.sv
// Result-channel / CDB bundle for cdb_arbiter.
//   master : execute/issue side. Drives flush, src_valid and src_payload.
//            Observes src_full and the CDB broadcast.
//   slave  : the arbiter.
// src_payload is flat. Channel i occupies [i*PAYLOAD_W +: PAYLOAD_W].
interface cdb_arbiter_if #(
  parameter int NUM_SRC   = 4,
  parameter int PAYLOAD_W = 82
);
  localparam int SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic                           flush;
  logic [NUM_SRC-1:0]             src_valid;
  logic [NUM_SRC*PAYLOAD_W-1:0]   src_payload;
  logic [NUM_SRC-1:0]             src_full;
  logic                           cdb_valid;
  logic [PAYLOAD_W-1:0]           cdb_payload;
  logic [SRC_W-1:0]               cdb_src;
  logic                           overflow;

  modport master (
    output flush, src_valid, src_payload,
    input  src_full, cdb_valid, cdb_payload, cdb_src, overflow
  );

  modport slave (
    input  flush, src_valid, src_payload,
    output src_full, cdb_valid, cdb_payload, cdb_src, overflow
  );
endinterface

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: buffers per-FU results in small FIFOs and serialises them onto
// a single registered common data bus.
//   clk, rst : clock, synchronous active-high reset
//   bus      : cdb_arbiter_if.slave
//              flush                   drop everything buffered / in flight
//              src_valid/src_payload   per-channel results
//              src_full                per-channel FIFO full
//              cdb_valid/payload/src   broadcast
//              overflow                sticky dropped-result flag
// The branch channel always wins. The others rotate from rr_ptr.

// Per-channel FIFO. A push at full is accepted when the head leaves in the
// same cycle. Otherwise it is reported on drop.
module cdb_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 82
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic         empty,
  output logic         full,
  output logic         drop
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DEPTH-1:0][W-1:0] mem;
  logic [PTR_W-1:0]        wr_ptr, rd_ptr;
  logic [CNT_W-1:0]        count;
  logic                    do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop & ~empty & ~flush;
  assign do_push = push & ~flush & (~full | do_pop);
  assign drop    = push & ~flush & full & ~do_pop;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Storage needs no reset. Occupancy is tracked by count alone.
  always_ff @(posedge clk) begin
    if (!rst && do_push) mem[wr_ptr] <= din;
  end
endmodule

module cdb_arbiter #(
  parameter int NUM_SRC   = 4,
  parameter int BR_IDX    = 3,
  parameter int BUF_DEPTH = 2,
  parameter int PAYLOAD_W = 82
) (
  input  logic          clk,
  input  logic          rst,
  cdb_arbiter_if.slave  bus
);
  localparam int SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [NUM_SRC-1:0][PAYLOAD_W-1:0] head;
  logic [NUM_SRC-1:0]                empty, full, pop, drop;
  logic                              gnt_vld;
  logic [SRC_W-1:0]                  gnt_idx, rr_ptr, rr_next;
  logic                              cdb_vld_q, ovf_q;
  logic [PAYLOAD_W-1:0]              cdb_pl_q;
  logic [SRC_W-1:0]                  cdb_src_q;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_ch
    cdb_fifo #(.DEPTH(BUF_DEPTH), .W(PAYLOAD_W)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (bus.flush),
      .push  (bus.src_valid[g]),
      .pop   (pop[g]),
      .din   (bus.src_payload[g*PAYLOAD_W +: PAYLOAD_W]),
      .head  (head[g]),
      .empty (empty[g]),
      .full  (full[g]),
      .drop  (drop[g])
    );
  end

  // Branch channel first. Otherwise take the first non-empty channel at or
  // after rr_ptr. The loop runs from the far end so the nearest match wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    if (!empty[BR_IDX]) begin
      gnt_vld = 1'b1;
      gnt_idx = SRC_W'(BR_IDX);
    end else begin
      for (int k = NUM_SRC - 1; k >= 0; k--) begin
        if (!empty[(int'(rr_ptr) + k) % NUM_SRC]) begin
          gnt_vld = 1'b1;
          gnt_idx = SRC_W'((int'(rr_ptr) + k) % NUM_SRC);
        end
      end
    end
  end

  assign rr_next = (int'(gnt_idx) == NUM_SRC - 1) ? '0 : gnt_idx + SRC_W'(1);

  always_comb begin
    pop = '0;
    if (gnt_vld && !bus.flush) pop[gnt_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr    <= '0;
      cdb_vld_q <= 1'b0;
      cdb_pl_q  <= '0;
      cdb_src_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      if (|drop) ovf_q <= 1'b1;
      if (bus.flush) begin
        cdb_vld_q <= 1'b0;
      end else begin
        cdb_vld_q <= gnt_vld;
        if (gnt_vld) begin
          cdb_pl_q  <= head[gnt_idx];
          cdb_src_q <= gnt_idx;
          if (gnt_idx != SRC_W'(BR_IDX)) rr_ptr <= rr_next;
        end
      end
    end
  end

  // Hide the broadcast already in the output register during the flush cycle.
  assign bus.cdb_valid   = cdb_vld_q & ~bus.flush;
  assign bus.cdb_payload = cdb_pl_q;
  assign bus.cdb_src     = cdb_src_q;
  assign bus.overflow    = ovf_q;
  assign bus.src_full    = full;
endmodule

// File: tb/tb_cdb_arbiter.sv
module tb_cdb_arbiter;
  localparam int N  = 4;
  localparam int BR = 3;
  localparam int D  = 2;
  localparam int W  = 82;

  typedef struct packed {
    logic [1:0]   src;
    logic [W-1:0] pl;
  } sb_t;

  logic clk, rst;
  logic [N-1:0]        v;
  logic [N-1:0][W-1:0] pl;
  logic                fl;
  logic                mon_en;
  int checks, errors;

  cdb_arbiter_if #(.NUM_SRC(N), .PAYLOAD_W(W)) bus();
  assign bus.src_valid   = v;
  assign bus.src_payload = pl;
  assign bus.flush       = fl;

  cdb_arbiter #(.NUM_SRC(N), .BR_IDX(BR), .BUF_DEPTH(D), .PAYLOAD_W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [W-1:0] mk(input int rob, input int rdv);
    logic [5:0]  r6;
    logic [31:0] d32;
    r6  = rob[5:0];
    d32 = rdv;
    return {r6, 6'd0, 5'd0, d32, 1'b0, 32'h0};
  endfunction

  function automatic logic [W-1:0] rnd_pl();
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    return r[W-1:0];
  endfunction

  // Reference model: one queue per channel, a rotating start index, and the
  // branch channel served first. Each grant is pushed to the scoreboard.
  logic [W-1:0] mq[N][$];
  sb_t          sbq[$];
  sb_t          obs[$];
  int           rr;
  logic         m_ovf;

  always @(posedge clk) begin
    int  g;
    sb_t se;
    if (rst) begin
      for (int i = 0; i < N; i++) mq[i].delete();
      rr = 0;
      m_ovf = 1'b0;
      sbq.delete();
    end else if (fl) begin
      for (int i = 0; i < N; i++) mq[i].delete();
    end else begin
      g = -1;
      if (mq[BR].size() > 0) g = BR;
      else
        for (int k = 0; k < N; k++)
          if (g < 0 && mq[(rr + k) % N].size() > 0) g = (rr + k) % N;
      if (g >= 0) begin
        se.src = g[1:0];
        se.pl  = mq[g].pop_front();
        sbq.push_back(se);
        if (g != BR) rr = (g + 1) % N;
      end
      for (int i = 0; i < N; i++)
        if (v[i]) begin
          if (mq[i].size() < D) mq[i].push_back(pl[i]);
          else m_ovf = 1'b1;
        end
    end
  end

  // Monitor: compares whatever the DUT broadcasts against the scoreboard.
  always @(negedge clk) begin
    logic [N-1:0] mf;
    sb_t e, a;
    if (mon_en) begin
      for (int i = 0; i < N; i++) mf[i] = (mq[i].size() == D);
      chk("src_full", bus.src_full, mf);
      chk("overflow", bus.overflow, m_ovf);
      if (fl) begin
        chk("flush_hide_valid", bus.cdb_valid, 1'b0);
        if (sbq.size() > 0) void'(sbq.pop_front());
      end else if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("cdb_valid", bus.cdb_valid, 1'b1);
        chk("cdb_src", bus.cdb_src, e.src);
        chk("cdb_payload", bus.cdb_payload, e.pl);
        a.src = bus.cdb_src;
        a.pl  = bus.cdb_payload;
        obs.push_back(a);
      end else begin
        chk("cdb_idle", bus.cdb_valid, 1'b0);
      end
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    @(negedge clk);
    chk({tag, "_valid"}, bus.cdb_valid, 1'b0);
    chk({tag, "_payload"}, bus.cdb_payload, '0);
    chk({tag, "_src"}, bus.cdb_src, '0);
    chk({tag, "_ovf"}, bus.overflow, 1'b0);
    chk({tag, "_full"}, bus.src_full, '0);
  endtask

  task automatic chk_seq(input string tag, input int exp_src[$]);
    chk({tag, "_count"}, obs.size(), exp_src.size());
    for (int k = 0; k < exp_src.size() && k < obs.size(); k++)
      chk({tag, "_src"}, obs[k].src, exp_src[k]);
  endtask

  initial begin
    checks = 0; errors = 0; mon_en = 1'b0;
    rst = 1'b1; v = '0; fl = 1'b0; pl = '0;
    nxt();
    mon_en = 1'b1;
    nxt();
    rst = 1'b0;
    chk_reset_outputs("reset");

    // 1: single add result, two-cycle latency
    nxt(); pl[0] = mk(5, 'h1234); v = 4'b0001;
    nxt(); v = '0;
    @(negedge clk); chk("t1_early", bus.cdb_valid, 1'b0);
    nxt();
    @(negedge clk);
    chk("t1_valid", bus.cdb_valid, 1'b1);
    chk("t1_rob", bus.cdb_payload[81:76], 6'd5);
    chk("t1_rdv", bus.cdb_payload[64:33], 32'h1234);
    chk("t1_src", bus.cdb_src, 2'd0);
    nxt();
    @(negedge clk); chk("t1_after", bus.cdb_valid, 1'b0);

    // 2: all channels at once, from a fresh rotation pointer
    rst = 1'b1; nxt(); rst = 1'b0;
    obs.delete();
    for (int i = 0; i < N; i++) pl[i] = mk(10 + i, i);
    v = 4'b1111;
    nxt(); v = '0;
    repeat (6) nxt();
    chk_seq("t2", '{3, 0, 1, 2});
    if (obs.size() == 4) chk("t2_rob_first", obs[0].pl[81:76], 6'd13);

    // 3: add/mul alternation with a branch slipping in
    obs.delete();
    pl[0] = mk(20, 0); pl[1] = mk(21, 0); v = 4'b0011;
    nxt(); pl[0] = mk(22, 0); pl[1] = mk(23, 0);
    nxt(); pl[3] = mk(24, 0); v = 4'b1000;
    nxt(); v = '0;
    repeat (8) nxt();
    chk_seq("t3", '{0, 1, 3, 0, 1});

    // 4: mul starved by a steady branch stream until it overflows
    obs.delete();
    pl[1] = mk(30, 0); pl[3] = mk(40, 0); v = 4'b1010;
    nxt(); pl[1] = mk(31, 0); pl[3] = mk(41, 0);
    nxt(); pl[1] = mk(32, 0); pl[3] = mk(42, 0);
    @(negedge clk); chk("t4_full", bus.src_full[1], 1'b1);
    nxt(); v = 4'b1000; pl[3] = mk(43, 0);
    @(negedge clk); chk("t4_ovf", bus.overflow, 1'b1);
    nxt(); pl[3] = mk(44, 0);
    nxt(); v = '0;
    repeat (8) nxt();
    chk_seq("t4", '{3, 3, 3, 3, 3, 1, 1});
    if (obs.size() == 7) begin
      chk("t4_mul_rob0", obs[5].pl[81:76], 6'd30);
      chk("t4_mul_rob1", obs[6].pl[81:76], 6'd31);
    end

    // 5: flush while a broadcast is registered and FIFOs hold entries
    obs.delete();
    pl[0] = mk(50, 0); pl[2] = mk(52, 0); pl[3] = mk(53, 0); v = 4'b1101;
    nxt(); pl[0] = mk(51, 0); v = 4'b0001;
    nxt(); v = '0; fl = 1'b1;
    @(negedge clk); chk("t5_hidden", bus.cdb_valid, 1'b0);
    nxt(); fl = 1'b0; pl[0] = mk(55, 0); v = 4'b0001;
    @(negedge clk);
    chk("t5_full", bus.src_full, 4'b0000);
    chk("t5_ovf", bus.overflow, 1'b1);
    chk("t5_quiet", bus.cdb_valid, 1'b0);
    nxt(); v = '0;
    @(negedge clk); chk("t5_quiet2", bus.cdb_valid, 1'b0);
    nxt();
    @(negedge clk);
    chk("t5_new_valid", bus.cdb_valid, 1'b1);
    chk("t5_new_rob", bus.cdb_payload[81:76], 6'd55);
    repeat (4) nxt();
    chk_seq("t5", '{0});

    // 6: reset mid-stream with buffered work and overflow set
    pl[0] = rnd_pl(); pl[1] = rnd_pl(); pl[2] = rnd_pl(); v = 4'b0111;
    nxt(); pl[0] = rnd_pl(); pl[1] = rnd_pl(); pl[2] = rnd_pl();
    nxt(); v = '0; rst = 1'b1;
    nxt(); rst = 1'b0;
    chk_reset_outputs("t6");
    obs.delete();
    repeat (4) nxt();
    chk("t6_no_bcast", obs.size(), 0);

    // Random traffic with occasional flushes and resets
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        v[i]  = ($urandom_range(0, 99) < 40);
        pl[i] = rnd_pl();
      end
      fl  = ($urandom_range(0, 49) == 0);
      rst = ($urandom_range(0, 499) == 0);
      nxt();
    end
    v = '0; fl = 1'b0; rst = 1'b0;
    repeat (12) nxt();
    chk("drain_scoreboard", sbq.size(), 0);
    chk("drain_idle", bus.cdb_valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
